// File: rtl/traffic_3way_pkg.sv
// Shared definitions for the three-way junction controller.
package traffic_3way_pkg;

    // Lamp codes; 2'b11 is never driven.
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Default phase lengths in clock cycles.
    localparam int unsigned G_TIME_DEFAULT = 10;
    localparam int unsigned Y_TIME_DEFAULT = 3;

    // Right of way rotates G1 -> Y1 -> G2 -> Y2 -> G3 -> Y3 -> G1.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StG1   = 3'd1,
        StY1   = 3'd2,
        StG2   = 3'd3,
        StY2   = 3'd4,
        StG3   = 3'd5,
        StY3   = 3'd6
    } state_e;

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase counter: counts cycles spent in the current lamp phase.
module traffic_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,  // terminal count, i.e. phase length minus one
    output logic             done
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Done on the last cycle of the phase, so the owner can switch on the next edge.
    assign done = (cnt_q == limit);

    // Clear on every phase change, so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_3way.sv
// Three-road junction controller: rotates green/yellow over roads 1, 2, 3.
module traffic_3way
    import traffic_3way_pkg::*;
#(
    parameter int unsigned G_TIME = G_TIME_DEFAULT,
    parameter int unsigned Y_TIME = Y_TIME_DEFAULT,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] l1,
    output logic [1:0] l2,
    output logic [1:0] l3
);

    localparam logic [CNT_W-1:0] GLimit = CNT_W'(G_TIME - 1);
    localparam logic [CNT_W-1:0] YLimit = CNT_W'(Y_TIME - 1);

    state_e           state_d, state_q;
    logic             timer_clear;
    logic             timer_done;
    logic [CNT_W-1:0] timer_limit;

    traffic_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .limit (timer_limit),
        .done  (timer_done)
    );

    // Next state and timer control; the timer is held clear outside timed phases.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b1;
        timer_limit = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StG1;
                end
            end
            StG1, StG2, StG3: begin
                timer_limit = GLimit;
                timer_clear = timer_done;
                if (timer_done) begin
                    case (state_q)
                        StG1:    state_d = StY1;
                        StG2:    state_d = StY2;
                        default: state_d = StY3;
                    endcase
                end
            end
            StY1, StY2, StY3: begin
                timer_limit = YLimit;
                timer_clear = timer_done;
                if (timer_done) begin
                    case (state_q)
                        StY1:    state_d = StG2;
                        StY2:    state_d = StG3;
                        default: state_d = StG1;
                    endcase
                end
            end
            // Unused encoding: recover to IDLE.
            default: state_d = StIdle;
        endcase
    end

    // State register; reset dominates start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore lamp decode from the state register only.
    always_comb begin
        l1 = LAMP_RED;
        l2 = LAMP_RED;
        l3 = LAMP_RED;
        case (state_q)
            StG1:    l1 = LAMP_GREEN;
            StY1:    l1 = LAMP_YELLOW;
            StG2:    l2 = LAMP_GREEN;
            StY2:    l2 = LAMP_YELLOW;
            StG3:    l3 = LAMP_GREEN;
            StY3:    l3 = LAMP_YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_3way.sv
// Bench for traffic_3way: default instance plus a G_TIME=2/Y_TIME=1 instance,
// both checked cycle by cycle against a reference model via scoreboards.
module tb_traffic_3way;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] l1, l2, l3;
    logic [1:0] m1, m2, m3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [5:0] exp_q_a[$];
    logic [5:0] exp_q_b[$];
    int ph_a = 0, cnt_a = 0;
    int ph_b = 0, cnt_b = 0;

    always #5 clk = ~clk;

    traffic_3way dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .l1    (l1),
        .l2    (l2),
        .l3    (l3)
    );

    traffic_3way #(
        .G_TIME (2),
        .Y_TIME (1),
        .CNT_W  (4)
    ) dut_small (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .l1    (m1),
        .l2    (m2),
        .l3    (m3)
    );

    // Phase 0 = idle, 1..6 = G1,Y1,G2,Y2,G3,Y3.
    task automatic model_step(input logic r, input logic s, input int g, input int y,
                              input int ph_i, input int cnt_i,
                              output int ph_o, output int cnt_o);
        int len;
        ph_o  = ph_i;
        cnt_o = cnt_i;
        if (r === 1'b1) begin
            ph_o  = 0;
            cnt_o = 0;
        end else if (ph_i == 0) begin
            if (s === 1'b1) begin
                ph_o  = 1;
                cnt_o = 0;
            end
        end else begin
            len = (ph_i % 2 == 1) ? g : y;
            if (cnt_i == len - 1) begin
                ph_o  = (ph_i == 6) ? 1 : ph_i + 1;
                cnt_o = 0;
            end else begin
                cnt_o = cnt_i + 1;
            end
        end
    endtask

    function automatic logic [5:0] model_lamps(input int ph);
        logic [5:0] v;
        int road;
        if (ph == 0) return 6'b0;
        road = (ph + 1) / 2;
        v = {4'b0, ((ph % 2 == 1) ? 2'b10 : 2'b01)};
        return v << (2 * (3 - road));
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b required %b", tag, cyc, obs, exp_v);
        end
    endtask

    // Drive inputs at the falling edge, predict, then compare 1 time unit after the edge.
    task automatic cycle(input logic r, input logic s);
        int pa, ca, pb, cb;
        rst   = r;
        start = s;
        model_step(r, s, 10, 3, ph_a, cnt_a, pa, ca);
        model_step(r, s, 2, 1, ph_b, cnt_b, pb, cb);
        ph_a = pa; cnt_a = ca;
        ph_b = pb; cnt_b = cb;
        exp_q_a.push_back(model_lamps(ph_a));
        exp_q_b.push_back(model_lamps(ph_b));
        @(posedge clk);
        #1;
        cyc++;
        check("lamps_default", {l1, l2, l3}, exp_q_a.pop_front());
        check("lamps_small", {m1, m2, m3}, exp_q_b.pop_front());
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_rise;
        logic [1:0] prev_m1;
        rst   = 1'b1;
        start = 1'bx;
        @(negedge clk);

        // Reset with start unknown.
        cycle(1'b1, 1'bx);
        check("reset_all_red", {l1, l2, l3}, 6'b0);
        cycle(1'b1, 1'bx);

        // Idle hold.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        check("idle_hold", {l1, l2, l3, m1, m2, m3}, 12'b0);

        // Start seen at E0; drop start during G2 (after E14).
        cycle(1'b0, 1'b1);
        check("e1_g1", {4'b0, l1}, {4'b0, 2'b10});
        for (int k = 1; k <= 63; k++) begin
            cycle(1'b0, (k < 15) ? 1'b1 : 1'b0);
            if (k == 9)  check("e10_g1", {4'b0, l1}, {4'b0, 2'b10});
            if (k == 10) check("e11_y1", {4'b0, l1}, {4'b0, 2'b01});
            if (k == 13) check("e14_g2", {l1, l2, l3}, 6'b00_10_00);
            if (k == 36) check("e37_y3", {l1, l2, l3}, 6'b00_00_01);
            if (k == 39) check("e40_g1", {l1, l2, l3}, 6'b10_00_00);
        end
        // Edge 63 leaves the default instance in Y2.
        check("in_y2", {l1, l2, l3}, 6'b00_01_00);

        // Reset mid-run, then restart at G1 for a full green.
        cycle(1'b1, 1'b0);
        check("midrun_reset", {l1, l2, l3}, 6'b0);
        cycle(1'b0, 1'b1);
        check("restart_g1", {l1, l2, l3}, 6'b10_00_00);

        // Free run with start low; measure small-instance period from l1 green onsets.
        last_rise = -1;
        prev_m1   = m1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0);
            if (i == 9) check("restart_y1", {l1, l2, l3}, 6'b01_00_00);
            if (m1 == 2'b10 && prev_m1 != 2'b10) begin
                if (last_rise >= 0) check("small_period", 6'(cyc - last_rise), 6'd9);
                last_rise = cyc;
            end
            prev_m1 = m1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
